interboard_msg_tx: RTL

Transmit side of the board-to-board move protocol. Accepts one move/state message per `ctrl_en` pulse from the game controller and latches it into a 24-bit frame. Sends the frame to the opposite board as four 6-bit chunks, each over a 4-phase req/ack handshake on the inter-board connector. Reports idle through `send_ready`, and flags completion, ack timeout and dropped requests.

---
 rtl/interboard_msg_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/interboard_msg_tx.sv
// Transmit side of the board-to-board move link: latches a 24-bit frame and sends it as four
// 6-bit chunks over a 4-phase req/ack handshake. Define INTERBOARD_PARITY_EN for frame parity.
module interboard_msg_tx #(
   parameter int unsigned ACK_TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ctrl_en,
   input  logic [3:0] ctrl_msg_type,
   input  logic [4:0] ctrl_block_x,
   input  logic [2:0] ctrl_block_y,
   input  logic [5:0] ctrl_card,
   input  logic [2:0] ctrl_sel_len,
   input  logic       ctrl_move_dir,
   input  logic       interboard_ack,
   output logic       send_ready,
   output logic       interboard_req,
   output logic [5:0] interboard_data,
   output logic       tx_done,
   output logic       tx_timeout,
   output logic       tx_drop
);

   localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StReqHi, StReqLo, StDone} state_e;

   state_e            state_q;
   logic [23:0]       frame_q;
   logic [1:0]        idx_q;
   logic [CntW-1:0]   cnt_q;
   logic              armed_q;
   logic              ack_meta_q;
   logic              ack_s;
   logic              parity;
   logic [23:0]       frame_in;
   logic [5:0]        chunk;

`ifdef INTERBOARD_PARITY_EN
   assign parity = ^{ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len,
                     ctrl_move_dir};
`else
   assign parity = 1'b0;
`endif

   assign frame_in = {ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len,
                      ctrl_move_dir, parity, 1'b0};

   // MSB chunk goes first
   always_comb begin
      chunk = frame_q[5:0];
      unique case (idx_q)
         2'd0: chunk = frame_q[23:18];
         2'd1: chunk = frame_q[17:12];
         2'd2: chunk = frame_q[11:6];
         2'd3: chunk = frame_q[5:0];
      endcase
   end

   assign send_ready = (state_q == StIdle);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_meta_q <= 1'b0;
         ack_s      <= 1'b0;
      end else begin
         ack_meta_q <= interboard_ack;
         ack_s      <= ack_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= StIdle;
         frame_q         <= '0;
         idx_q           <= '0;
         cnt_q           <= '0;
         armed_q         <= 1'b0;
         interboard_req  <= 1'b0;
         interboard_data <= '0;
         tx_done         <= 1'b0;
         tx_timeout      <= 1'b0;
         tx_drop         <= 1'b0;
      end else begin
         tx_done    <= 1'b0;
         tx_timeout <= 1'b0;
         tx_drop    <= ctrl_en && (state_q != StIdle);
         case (state_q)
            StIdle: begin
               if (ctrl_en) begin
                  frame_q <= frame_in;
                  idx_q   <= '0;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               interboard_data <= chunk;
               interboard_req  <= 1'b0;
               cnt_q           <= '0;
               state_q         <= StReqHi;
            end
            StReqHi: begin
               if (!interboard_req) begin
                  // An ack already high here is stale; it must fall before one is accepted.
                  interboard_req <= 1'b1;
                  cnt_q          <= '0;
                  armed_q        <= ~ack_s;
               end else if (cnt_q == CntLast) begin
                  tx_timeout      <= 1'b1;
                  interboard_req  <= 1'b0;
                  interboard_data <= '0;
                  frame_q         <= '0;
                  state_q         <= StIdle;
               end else if (ack_s && armed_q) begin
                  interboard_req <= 1'b0;
                  cnt_q          <= '0;
                  state_q        <= StReqLo;
               end else begin
                  if (!ack_s) armed_q <= 1'b1;
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StReqLo: begin
               if (cnt_q == CntLast) begin
                  tx_timeout      <= 1'b1;
                  interboard_data <= '0;
                  frame_q         <= '0;
                  state_q         <= StIdle;
               end else if (!ack_s) begin
                  if (idx_q == 2'd3) begin
                     tx_done         <= 1'b1;
                     interboard_data <= '0;
                     state_q         <= StDone;
                  end else begin
                     idx_q   <= idx_q + 2'd1;
                     state_q <= StSetup;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            // Holds off IDLE for the tx_done cycle so a request then is reported as dropped
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
